// File: rtl/tcdm_bfly_core.sv
// Butterfly network from NumIn initiators to NumOut banks. Requests and grants are
// combinational; each initiator has a RespLat-deep response token pipeline.
module tcdm_bfly_core #(
  parameter int unsigned NumIn         = 32,
  parameter int unsigned NumOut        = 64,
  parameter int unsigned ReqDataWidth  = 32,
  parameter int unsigned RespDataWidth = 32,
  parameter int unsigned RespLat       = 1,
  parameter int unsigned Radix         = 2,
  parameter bit          WriteRespOn   = 1'b1,
  parameter bit          ExtPrio       = 1'b0,
  localparam int unsigned L = $clog2(NumOut)
) (
  input  logic                                    clk_i,
  input  logic                                    rst_i,
  input  logic [L-1:0]                            rr_i,
  input  logic [NumIn-1:0]                        req_i,
  input  logic [NumIn-1:0][L-1:0]                 add_i,
  input  logic [NumIn-1:0]                        wen_i,
  input  logic [NumIn-1:0][ReqDataWidth-1:0]      wdata_i,
  output logic [NumIn-1:0]                        gnt_o,
  output logic [NumIn-1:0]                        vld_o,
  output logic [NumIn-1:0][RespDataWidth-1:0]     rdata_o,
  output logic [NumOut-1:0]                       req_o,
  input  logic [NumOut-1:0]                       gnt_i,
  output logic [NumOut-1:0][ReqDataWidth-1:0]     wdata_o,
  input  logic [NumOut-1:0][RespDataWidth-1:0]    rdata_i
);

  localparam int unsigned NumStages = (Radix == 4) ? (L + 1) / 2 : L;
  localparam bit          Odd4      = (Radix == 4) && (L % 2 == 1);
  localparam int unsigned Stride    = NumOut / NumIn;
  localparam int unsigned IdxW      = (NumIn > 1) ? $clog2(NumIn) : 1;

  // With radix 4 and odd L, digit 0 is the lone LSB and higher digits shift down one bit.
  function automatic int dig_lo(input int d);
    if (Radix == 2) return d;
    if (Odd4) return (d == 0) ? 0 : 2 * d - 1;
    return 2 * d;
  endfunction

  function automatic int dig_w(input int d);
    if (Radix == 2) return 1;
    if (Odd4 && d == 0) return 1;
    return 2;
  endfunction

  logic [NumOut-1:0]       net_req  [NumStages+1];
  logic [L-1:0]            net_add  [NumStages+1][NumOut];
  logic [ReqDataWidth-1:0] net_data [NumStages+1][NumOut];
  logic [IdxW-1:0]         net_src  [NumStages+1][NumOut];
  logic [1:0]              win      [NumStages][NumOut];
  logic [1:0]              ptr_q    [NumStages][NumOut];

  always_comb begin
    int   lo, r, base, qd, pt, m, p;
    logic found;
    lo = 0; r = 2; base = 0; qd = 0; pt = 0; m = 0; p = 0; found = 1'b0;
    for (int s = 0; s <= NumStages; s++) begin
      net_req[s] = '0;
      for (int q = 0; q < NumOut; q++) begin
        net_add[s][q]  = '0;
        net_data[s][q] = '0;
        net_src[s][q]  = '0;
      end
    end
    for (int s = 0; s < NumStages; s++)
      for (int q = 0; q < NumOut; q++) win[s][q] = '0;
    for (int i = 0; i < NumIn; i++) begin
      net_req[0][i*Stride]  = req_i[i];
      net_add[0][i*Stride]  = add_i[i];
      net_data[0][i*Stride] = wdata_i[i];
      net_src[0][i*Stride]  = IdxW'(i);
    end
    for (int s = 0; s < NumStages; s++) begin
      lo = dig_lo(NumStages - 1 - s);
      r  = 1 << dig_w(NumStages - 1 - s);
      for (int q = 0; q < NumOut; q++) begin
        qd    = (q >> lo) % r;
        base  = q - (qd << lo);
        pt    = ExtPrio ? (int'(rr_i) >> lo) % r : int'(ptr_q[s][q]);
        found = 1'b0;
        // Circular scan of the group starting at the priority pointer.
        for (int k = 0; k < 4; k++) begin
          m = (pt + k) % r;
          p = base + (m << lo);
          if (k < r && !found && net_req[s][p] &&
              ((int'(net_add[s][p]) >> lo) % r) == qd) begin
            found              = 1'b1;
            net_req[s+1][q]    = 1'b1;
            net_add[s+1][q]    = net_add[s][p];
            net_data[s+1][q]   = net_data[s][p];
            net_src[s+1][q]    = net_src[s][p];
            win[s][q]          = 2'(m);
          end
        end
      end
    end
  end

  assign req_o = net_req[NumStages];

  always_comb begin
    gnt_o = '0;
    for (int b = 0; b < NumOut; b++) begin
      wdata_o[b] = net_data[NumStages][b];
      if (net_req[NumStages][b] && gnt_i[b]) gnt_o[net_src[NumStages][b]] = 1'b1;
    end
  end

  // A switch output advances its pointer only when its winner reaches a granting bank.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int s = 0; s < NumStages; s++)
        for (int q = 0; q < NumOut; q++) ptr_q[s][q] <= '0;
    end else begin
      for (int s = 0; s < NumStages; s++)
        for (int q = 0; q < NumOut; q++)
          if (net_req[s+1][q] && gnt_o[net_src[s+1][q]])
            ptr_q[s][q] <= 2'((int'(win[s][q]) + 1) % (1 << dig_w(NumStages - 1 - s)));
    end
  end

  logic [NumIn-1:0] tok_vld  [RespLat];
  logic [L-1:0]     tok_bank [RespLat][NumIn];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int d = 0; d < RespLat; d++) begin
        tok_vld[d] <= '0;
        for (int i = 0; i < NumIn; i++) tok_bank[d][i] <= '0;
      end
    end else begin
      for (int i = 0; i < NumIn; i++) begin
        tok_vld[0][i]  <= gnt_o[i] && (!wen_i[i] || WriteRespOn);
        tok_bank[0][i] <= add_i[i];
      end
      for (int d = 1; d < RespLat; d++) begin
        tok_vld[d]  <= tok_vld[d-1];
        tok_bank[d] <= tok_bank[d-1];
      end
    end
  end

  always_comb begin
    vld_o = tok_vld[RespLat-1];
    for (int i = 0; i < NumIn; i++)
      rdata_o[i] = tok_vld[RespLat-1][i] ? rdata_i[tok_bank[RespLat-1][i]] : '0;
  end

endmodule

// File: tb/tb_tcdm_bfly_core.sv
// Bench for tcdm_bfly_core: 4x4 radix-2 network, RespLat=1, with a second instance
// that has store responses disabled.
module tb_tcdm_bfly_core;
  localparam int NI = 4, NO = 4, L = 2, DW = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [L-1:0]              rr;
  logic [NI-1:0]             req, wen, gnt, vld, gnt_nw, vld_nw;
  logic [NI-1:0][L-1:0]      add;
  logic [NI-1:0][DW-1:0]     wdata, rdata, rdata_nw;
  logic [NO-1:0]             breq, bgnt, breq_nw;
  logic [NO-1:0][DW-1:0]     bwdata, brdata, bwdata_nw;

  tcdm_bfly_core #(.NumIn(NI), .NumOut(NO), .ReqDataWidth(DW), .RespDataWidth(DW),
                   .RespLat(1), .Radix(2), .WriteRespOn(1'b1), .ExtPrio(1'b0)) dut (
    .clk_i(clk), .rst_i(rst), .rr_i(rr), .req_i(req), .add_i(add), .wen_i(wen),
    .wdata_i(wdata), .gnt_o(gnt), .vld_o(vld), .rdata_o(rdata), .req_o(breq),
    .gnt_i(bgnt), .wdata_o(bwdata), .rdata_i(brdata));

  tcdm_bfly_core #(.NumIn(NI), .NumOut(NO), .ReqDataWidth(DW), .RespDataWidth(DW),
                   .RespLat(1), .Radix(2), .WriteRespOn(1'b0), .ExtPrio(1'b0)) dut_nw (
    .clk_i(clk), .rst_i(rst), .rr_i(rr), .req_i(req), .add_i(add), .wen_i(wen),
    .wdata_i(wdata), .gnt_o(gnt_nw), .vld_o(vld_nw), .rdata_o(rdata_nw), .req_o(breq_nw),
    .gnt_i(bgnt), .wdata_o(bwdata_nw), .rdata_i(brdata));

  typedef struct {
    logic [NI-1:0]         vld;
    logic [NI-1:0][DW-1:0] rdata;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0, failures = 0, cyc = 0;

  function automatic logic [DW-1:0] bank_data(input int c, input int b);
    logic [15:0] hi;
    hi = 16'(c);
    return {hi, 16'hB000 | 16'(b)};
  endfunction

  task automatic set_rdata();
    for (int b = 0; b < NO; b++) brdata[b] = bank_data(cyc, b);
  endtask

  task automatic idle();
    req = '0; wen = '0; add = '0; wdata = '0; bgnt = '1;
  endtask

  // Pushes the response expected one cycle after this edge, then advances a cycle.
  task automatic tick(input logic [NI-1:0] ev, input logic [NI-1:0][L-1:0] eb);
    exp_t e;
    e.vld = ev;
    for (int i = 0; i < NI; i++) e.rdata[i] = ev[i] ? bank_data(cyc + 1, int'(eb[i])) : '0;
    exp_q.push_back(e);
    @(posedge clk);
    cyc++;
    set_rdata();
    @(negedge clk);
  endtask

  always @(posedge clk) begin : monitor
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (vld !== e.vld) begin
        failures++;
        $display("FAIL resp_vld cyc=%0d: got %b expected %b", cyc, vld, e.vld);
      end
      checks++;
      if (rdata !== e.rdata) begin
        failures++;
        $display("FAIL resp_rdata cyc=%0d: got %h expected %h", cyc, rdata, e.rdata);
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1; idle();
    tick('0, '0);
    checks++;
    if (vld !== '0 || rdata !== '0) begin
      failures++; $display("FAIL reset_resp: got vld=%b rdata=%h expected 0", vld, rdata);
    end
    checks++;
    if (breq !== '0 || gnt !== '0 || bwdata !== '0) begin
      failures++; $display("FAIL reset_net: got req_o=%b gnt_o=%b expected 0", breq, gnt);
    end
    tick('0, '0);
    rst = 1'b0;
  endtask

  task automatic test_single_load();
    logic [NO-1:0][DW-1:0] ew;
    logic [NI-1:0][L-1:0]  eb;
    idle();
    req = 4'b0001; add[0] = 2'd2; wdata[0] = 32'hA5;
    ew = '0; ew[2] = 32'hA5; eb = '0; eb[0] = 2'd2;
    #1;
    checks++;
    if (breq !== 4'b0100) begin
      failures++; $display("FAIL single_req_o: got %b expected 0100", breq);
    end
    checks++;
    if (bwdata !== ew) begin
      failures++; $display("FAIL single_wdata_o: got %h expected %h", bwdata, ew);
    end
    checks++;
    if (gnt !== 4'b0001) begin
      failures++; $display("FAIL single_gnt_o: got %b expected 0001", gnt);
    end
    tick(4'b0001, eb);
    idle();
  endtask

  // Conflict-free permutations issued back to back, loads and stores mixed.
  task automatic test_back_to_back();
    logic [NO-1:0][DW-1:0] ew;
    logic [1:0] pat [3];
    pat[0] = 2'd0; pat[1] = 2'd3; pat[2] = 2'd1;
    for (int t = 0; t < 3; t++) begin
      req = 4'b1111; bgnt = '1;
      wen = (t == 2) ? 4'b0101 : 4'b0000;
      ew = '0;
      for (int i = 0; i < NI; i++) begin
        add[i]   = 2'(i) ^ pat[t];
        wdata[i] = 32'h100 + 32'(t * 16 + i);
        ew[int'(add[i])] = wdata[i];
      end
      #1;
      checks++;
      if (gnt !== 4'b1111 || breq !== 4'b1111) begin
        failures++; $display("FAIL b2b_gnt pat=%0d: got gnt=%b req=%b expected 1111", t, gnt, breq);
      end
      checks++;
      if (bwdata !== ew) begin
        failures++; $display("FAIL b2b_wdata pat=%0d: got %h expected %h", t, bwdata, ew);
      end
      tick(4'b1111, add);
    end
    idle();
  endtask

  task automatic test_fairness();
    logic [NI-1:0] eg;
    logic [NI-1:0][L-1:0] eb;
    idle();
    tick('0, '0);
    rst = 1'b1; #1; rst = 1'b0;
    req = 4'b0011; add[0] = 2'd3; add[1] = 2'd3;
    wdata[0] = 32'hAAAA0000; wdata[1] = 32'hBBBB1111;
    eb = '0; eb[0] = 2'd3; eb[1] = 2'd3;
    for (int c = 0; c < 4; c++) begin
      eg = (c % 2 == 0) ? 4'b0001 : 4'b0010;
      #1;
      checks++;
      if (gnt !== eg) begin
        failures++; $display("FAIL fair_gnt c=%0d: got %b expected %b", c, gnt, eg);
      end
      checks++;
      if (breq !== 4'b1000 || bwdata[3] !== ((c % 2 == 0) ? wdata[0] : wdata[1])) begin
        failures++; $display("FAIL fair_bank c=%0d: got req=%b data=%h", c, breq, bwdata[3]);
      end
      tick(eg, eb);
    end
    idle();
  endtask

  task automatic test_backpressure();
    logic [NI-1:0][L-1:0] eb;
    idle();
    bgnt = 4'b1101;
    req = 4'b0101; add[0] = 2'd1; add[2] = 2'd2;
    eb = '0; eb[2] = 2'd2;
    #1;
    checks++;
    if (breq !== 4'b0110) begin
      failures++; $display("FAIL bp_req_o: got %b expected 0110", breq);
    end
    checks++;
    if (gnt !== 4'b0100) begin
      failures++; $display("FAIL bp_gnt_o: got %b expected 0100", gnt);
    end
    tick(4'b0100, eb);
    idle();
  endtask

  task automatic test_store();
    logic [NI-1:0][L-1:0] eb;
    idle();
    req = 4'b0001; wen = 4'b0001; add[0] = 2'd1; wdata[0] = 32'h5A;
    eb = '0; eb[0] = 2'd1;
    #1;
    checks++;
    if (gnt !== 4'b0001 || gnt_nw !== 4'b0001) begin
      failures++; $display("FAIL store_gnt: got %b/%b expected 0001/0001", gnt, gnt_nw);
    end
    tick(4'b0001, eb);
    idle();
    checks++;
    if (vld_nw !== '0 || rdata_nw !== '0) begin
      failures++; $display("FAIL store_noresp: got vld=%b rdata=%h expected 0", vld_nw, rdata_nw);
    end
  endtask

  task automatic test_reset_midflight();
    idle();
    req = 4'b0001; add[0] = 2'd2; wdata[0] = 32'h77;
    #1;
    checks++;
    if (gnt !== 4'b0001) begin
      failures++; $display("FAIL midflight_gnt: got %b expected 0001", gnt);
    end
    rst = 1'b1;
    tick('0, '0);
    idle();
    rst = 1'b0;
  endtask

  initial begin
    rr = '0; idle(); set_rdata();
    test_reset();
    test_single_load();
    test_back_to_back();
    test_fairness();
    test_backpressure();
    test_store();
    test_reset_midflight();
    test_single_load();
    tick('0, '0);
    tick('0, '0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
